// File: rtl/roc_arbiter_pkg.sv
// Shared parameters and state encoding for the read-once-clear mailbox arbiter.
// The FSM encoding and the index-width helper are shared by the top and the picker.
package roc_arbiter_pkg;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 4;
  localparam int DEP_DEF  = 16;
  localparam int NREQ_DEF = 2;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Width of a requester index; never below one bit, so a single requester still works.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/roc_rr_pick.sv
// Combinational round-robin picker: the first valid requester found when
// scanning upward from pri (wrapping) wins.
module roc_rr_pick
  import roc_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   pri,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Scan requesters starting at pri and keep only the first valid one.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(pri) + k) % NREQ);
      if (!any && req_valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/roc_arbiter.sv
// Round-robin sequencer sharing one read-once-clear mailbox between NREQ requesters.
// Each accepted op takes three cycles: ARB (accept), ACCESS (memory update), RESP (strobe).
module roc_arbiter
  import roc_arbiter_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int DEP  = DEP_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_hit,
  output logic [AW:0]       occupancy
);

  localparam int IW = idx_w(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   pri_q, pri_d;
  logic [IW-1:0]   win_q, win_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   mem_q [DEP];
  logic [DW-1:0]   mem_d [DEP];
  logic [DEP-1:0]  vld_q, vld_d;
  logic [AW:0]     occ_q, occ_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_hit_q, rsp_hit_d;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  roc_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_valid (req_valid),
    .pri       (pri_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  // Next-state logic for the FSM, storage and response registers.
  always_comb begin
    state_d     = state_q;
    pri_d       = pri_q;
    win_d       = win_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_d       = mem_q;
    vld_d       = vld_q;
    occ_d       = occ_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    req_ready   = '0;

    case (state_q)
      ST_ARB: begin
        if (pick_any) begin
          req_ready = pick_grant;
          win_d     = pick_idx;
          wr_d      = req_wr[pick_idx];
          addr_d    = req_addr[pick_idx*AW +: AW];
          data_d    = req_data[pick_idx*DW +: DW];
          state_d   = ST_ACCESS;
        end else begin
          state_d = ST_ARB;
        end
      end

      ST_ACCESS: begin
        rsp_data_d = '0;
        rsp_hit_d  = 1'b0;
        if (wr_q) begin
          // A write into an occupied entry is dropped rather than overwriting unread data.
          if (!vld_q[addr_q]) begin
            mem_d[addr_q] = data_q;
            vld_d[addr_q] = 1'b1;
            rsp_hit_d     = 1'b1;
            occ_d         = occ_q + (AW+1)'(1);
          end else begin
            rsp_hit_d = 1'b0;
          end
        end else begin
          if (vld_q[addr_q]) begin
            rsp_data_d    = mem_q[addr_q];
            rsp_hit_d     = 1'b1;
            mem_d[addr_q] = '0;
            vld_d[addr_q] = 1'b0;
            occ_d         = occ_q - (AW+1)'(1);
          end else begin
            rsp_hit_d = 1'b0;
          end
        end
        rsp_valid_d        = '0;
        rsp_valid_d[win_q] = 1'b1;
        state_d            = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_hit_d   = 1'b0;
        pri_d       = (win_q == IW'(NREQ-1)) ? '0 : win_q + IW'(1);
        state_d     = ST_ARB;
      end

      default: begin
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_hit_d   = 1'b0;
        state_d     = ST_ARB;
      end
    endcase
  end

  // State and storage registers; reset clears the mailbox and discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      pri_q       <= '0;
      win_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      for (int i = 0; i < DEP; i++) begin
        mem_q[i] <= '0;
      end
      vld_q       <= '0;
      occ_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pri_q       <= pri_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_q       <= mem_d;
      vld_q       <= vld_d;
      occ_q       <= occ_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_roc_arbiter.sv
// Scoreboard bench for roc_arbiter: a mailbox model predicts grants and responses,
// a separate monitor pops expectations whenever a response strobe appears.
module tb_roc_arbiter;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int DEP  = 16;
  localparam int NREQ = 2;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
    logic          hit;
    int            occ;
    int            cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_wr = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_hit;
  logic [AW:0]        occupancy;

  roc_arbiter #(.DW(DW), .AW(AW), .DEP(DEP), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_hit   (rsp_hit),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference mailbox: contents, occupied flags, count, and arbitration pointer.
  logic [DW-1:0] m_mem [DEP];
  bit            m_full [DEP];
  int            m_cnt;
  int            m_pri;
  int            free_cyc;

  op_t  opq [NREQ][$];
  op_t  cur [NREQ];
  bit   acc [NREQ];
  exp_t exp_q [$];
  exp_t me;
  int   grant_log [$];

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) begin
      m_mem[i]  = '0;
      m_full[i] = 1'b0;
    end
    m_cnt    = 0;
    m_pri    = 0;
    free_cyc = 0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    req_valid = '0;
  endtask

  // Predict the grant for this cycle and, on a grant, the response it must produce.
  task automatic check_arb();
    logic [NREQ-1:0] exp_rdy;
    int   w;
    int   a;
    exp_t e;
    exp_rdy = '0;
    w = -1;
    if (cyc >= free_cyc) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_pri + k) % NREQ;
        if (w < 0 && req_valid[i]) begin
          w = i;
          exp_rdy[i] = 1'b1;
        end
      end
    end
    check("req_ready", req_ready, exp_rdy);
    if (w >= 0) begin
      a = int'(cur[w].addr);
      e.who  = w;
      e.cyc  = cyc;
      e.data = '0;
      e.hit  = 1'b0;
      if (cur[w].wr) begin
        if (!m_full[a]) begin
          m_mem[a]  = cur[w].data;
          m_full[a] = 1'b1;
          m_cnt++;
          e.hit = 1'b1;
        end
      end else if (m_full[a]) begin
        e.data    = m_mem[a];
        e.hit     = 1'b1;
        m_mem[a]  = '0;
        m_full[a] = 1'b0;
        m_cnt--;
      end
      e.occ = m_cnt;
      exp_q.push_back(e);
      grant_log.push_back(w);
      free_cyc = cyc + 3;
      m_pri    = (w + 1) % NREQ;
      acc[w]   = 1'b1;
    end
  endtask

  task automatic step(input int gap_pct);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        req_valid[i] = 1'b0;
        acc[i] = 1'b0;
      end
      if (!req_valid[i] && opq[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        cur[i] = opq[i].pop_front();
        req_valid[i] = 1'b1;
        req_wr[i] = cur[i].wr;
        req_addr[i*AW +: AW] = cur[i].addr;
        req_data[i*DW +: DW] = cur[i].data;
      end
    end
    @(negedge clk);
    check_arb();
  endtask

  task automatic run_phase(input string name, input int gap_pct);
    int budget;
    budget = 0;
    while (opq[0].size() + opq[1].size() > 0 || req_valid != '0 || exp_q.size() > 0) begin
      step(gap_pct);
      budget++;
      if (budget > 3000) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_timeout: phase still busy after %0d cycles", name, budget);
        break;
      end
    end
    check({name, "_occupancy"}, occupancy, m_cnt);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Response monitor: every strobe must match the oldest expectation, exactly two cycles after its grant.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 2) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_missing: no response for grant to req%0d at cycle %0d", exp_q[0].who, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid %0b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
        end else begin
          me = exp_q.pop_front();
          check("rsp_valid", rsp_valid, NREQ'(1) << me.who);
          check("rsp_data", rsp_data, me.data);
          check("rsp_hit", rsp_hit, me.hit);
          check("rsp_occupancy", occupancy, me.occ);
          check("rsp_latency", cyc, me.cyc + 2);
        end
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_hit", rsp_hit, 0);
    check("reset_occupancy", occupancy, 0);
    repeat (10) step(0);

    // Write then two read-onces of the same address.
    opq[0].push_back('{1'b1, 4'd3, 8'hA5});
    opq[0].push_back('{1'b0, 4'd3, 8'h00});
    opq[0].push_back('{1'b0, 4'd3, 8'h00});
    run_phase("roc", 0);

    // Second write to an occupied entry is dropped.
    opq[0].push_back('{1'b1, 4'd5, 8'h11});
    opq[0].push_back('{1'b1, 4'd5, 8'h22});
    opq[0].push_back('{1'b0, 4'd5, 8'h00});
    run_phase("nooverwrite", 0);

    // Both requesters continuously valid: grants must alternate starting at req0.
    do_reset();
    grant_log.delete();
    for (int a = 0; a < 4; a++) begin
      opq[0].push_back('{1'b1, AW'(a), DW'($urandom)});
      opq[1].push_back('{1'b0, AW'(a), 8'h00});
    end
    run_phase("alternate", 0);
    check("alt_grants", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size(); k++) check("alt_order", grant_log[k], k % 2);

    // Fill every entry, then drain them all.
    for (int a = 0; a < DEP; a++) opq[a % 2].push_back('{1'b1, AW'(a), DW'($urandom)});
    run_phase("fill", 0);
    check("fill_full", occupancy, DEP);
    for (int a = 0; a < DEP; a++) opq[(a + 1) % 2].push_back('{1'b0, AW'(a), 8'h00});
    run_phase("drain", 0);
    check("drain_empty", occupancy, 0);

    // Reset during ACCESS of a write: the op vanishes without a response.
    opq[0].push_back('{1'b1, 4'd7, 8'h3C});
    begin
      int k;
      k = 0;
      while (!acc[0] && k < 20) begin
        step(0);
        k++;
      end
    end
    check("rst_write_accepted", acc[0], 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) step(0);
    check("rst_occupancy", occupancy, 0);
    opq[0].push_back('{1'b0, 4'd7, 8'h00});
    run_phase("rst_read", 0);

    // Random traffic on a few addresses so hits, misses and drops all occur.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        opq[i].push_back('{1'($urandom_range(1)), AW'($urandom_range(3)), DW'($urandom)});
      end
    end
    run_phase("random", 30);

    repeat (5) step(0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
